// File: rtl/dm_cache.sv
// Direct-mapped cache tag model. It does one lookup per clock and
// allocates the line on a miss. It keeps running hit and miss counters
// and holds no data payload.
module dm_cache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_BITS  = 10,
  parameter int OFFSET_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [31:0]           hitCount,
  output logic [31:0]           missCount
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_array [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  unused_offset;

  // The byte offset plays no part in the lookup.
  assign unused_offset = ^address[OFFSET_BITS-1:0];

  // Split the address and look it up against the pre-edge array state.
  always_comb begin
    idx = address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    tag = address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
    hit = valid[idx] && (tag_array[idx] == tag);
  end

  // Update the valid bits and the counters. Reset invalidates every line,
  // and the cycle it is asserted is not counted as an access.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= '0;
      hitCount  <= '0;
      missCount <= '0;
    end else if (hit) begin
      hitCount  <= hitCount + 32'd1;
    end else begin
      missCount  <= missCount + 32'd1;
      valid[idx] <= 1'b1;
    end
  end

  // Write the tag on a miss. Tags need no reset, because a line is only
  // read through its valid bit.
  always_ff @(posedge clk) begin
    if (!reset && !hit) tag_array[idx] <= tag;
  end

  initial begin : param_check
    if (TAG_BITS < 1) $error("dm_cache: TAG_BITS must be >= 1");
  end

endmodule

// File: tb/tb_dm_cache.sv
// Scoreboard bench for dm_cache. The driver pushes the expected counters
// into a queue for each edge. The monitor pops one entry after every edge
// and compares it with the DUT outputs.
module tb_dm_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'h0;
  logic [31:0] hitCount, missCount;

  dm_cache dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .hitCount  (hitCount),
    .missCount (missCount)
  );

  always #5 clk = ~clk;

  // Reference model: a map from line index to resident tag, plus counters.
  int unsigned line_tag [int unsigned];
  logic [31:0] m_hit, m_miss;
  logic [63:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  bit driver_done = 0;

  function automatic void model_access(input logic [31:0] a);
    int unsigned ix, tg;
    ix = (a / 64) % 1024;
    tg = a / 65536;
    if (line_tag.exists(ix) && line_tag[ix] == tg) m_hit = m_hit + 1;
    else begin
      m_miss = m_miss + 1;
      line_tag[ix] = tg;
    end
  endfunction

  task automatic access(input logic [31:0] a);
    @(negedge clk);
    reset = 1'b0;
    address = a;
    model_access(a);
    exp_q.push_back({m_hit, m_miss});
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      reset = 1'b1;
      address = $urandom;
      line_tag.delete();
      m_hit = 0;
      m_miss = 0;
      exp_q.push_back({m_hit, m_miss});
    end
  endtask

  // Wait for the edge that samples the inputs already driven, then check the
  // counters against constants that come from hand analysis.
  task automatic check_const(input string name, input logic [31:0] eh, input logic [31:0] em);
    @(posedge clk);
    #2;
    vectors++;
    if (hitCount !== eh || missCount !== em) begin
      miscompares++;
      $display("FAIL %s: got hit=%0d miss=%0d, want hit=%0d miss=%0d",
               name, hitCount, missCount, eh, em);
    end
  endtask

  // Monitor: after each edge, compare the DUT counters with the next queued expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (hitCount !== e[63:32] || missCount !== e[31:0]) begin
          miscompares++;
          $display("FAIL sb t=%0t: got hit=%h miss=%h, want hit=%h miss=%h",
                   $time, hitCount, missCount, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Driver: directed cases from the test plan, then a random trace.
  initial begin
    m_hit = 0;
    m_miss = 0;

    do_reset(2);
    check_const("reset", 0, 0);

    access(32'h0000_1000);
    access(32'h0000_1000);
    access(32'h0000_103C);
    check_const("same_block", 2, 1);

    do_reset(1);
    repeat (4) begin
      access(32'h0000_0040);
      access(32'h0001_0040);
    end
    check_const("ping_pong", 0, 8);

    do_reset(1);
    repeat (2)
      for (int i = 0; i < 1024; i++) access(i * 32'h40);
    check_const("sweep", 1024, 1024);

    do_reset(1);
    access(32'h0000_2000);
    access(32'h0000_2000);
    check_const("pre_reset", 1, 1);
    do_reset(1);
    check_const("mid_reset", 0, 0);
    access(32'h0000_2000);
    check_const("post_reset", 0, 1);

    // Counter wrap: deposit all-ones into hitCount, then make one hit.
    @(negedge clk);
    dut.hitCount = 32'hFFFF_FFFF;
    m_hit = 32'hFFFF_FFFF;
    reset = 1'b0;
    address = 32'h0000_2004;
    model_access(address);
    exp_q.push_back({m_hit, m_miss});
    check_const("wrap", 0, 1);

    // Random trace over a small index/tag pool, so that hits, cold misses and
    // conflict evictions all occur; resets are inserted occasionally.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset(1);
      else access(($urandom_range(0, 3) << 16) | ($urandom_range(0, 7) << 6) |
                  $urandom_range(0, 63));
    end

    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    driver_done = 1;
  end

  // Summary, plus a time bound in case the driver never finishes.
  initial begin
    fork
      wait (driver_done);
      begin
        #200000;
        miscompares++;
        $display("FAIL timeout: driver still running, want done");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_cache.md
Name: dm_cache

Overview:
- Direct-mapped cache tag model for trace-driven hit/miss statistics.
- Takes one 32-bit byte address per clock and performs a tag lookup; on a miss it allocates the line.
- Keeps running 32-bit hit and miss counters.
- Holds no data payload; tags and valid bits only. Sits under a trace-replay bench that reads the counters at end of trace.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- INDEX_BITS, 10, log2(number of lines); 1024 lines.
- OFFSET_BITS, 6, log2(block size in bytes); 64-byte blocks.
- Derived, not overridable: TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS (16 by default). Requirement: TAG_BITS >= 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_WIDTH  byte address of the access in this cycle.
- hitCount  output  32  total hits since last reset.
- missCount  output  32  total misses since last reset.

Behaviour:
- Address split:
  - offset = address[OFFSET_BITS-1:0], ignored.
  - index = address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS].
  - tag = address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS].
- State: valid[2^INDEX_BITS] bits, tag_array[2^INDEX_BITS] x TAG_BITS, hitCount and missCount registers.
- Reset (reset=1 at a rising edge):
  - hitCount=0, missCount=0.
  - All valid bits cleared.
  - Tag array contents don't-care.
  - No access is counted in that cycle.
  - Reset asserted mid-trace discards all cached state and counts.
- Access: every rising edge with reset=0 is exactly one access. There is no enable and no handshake.
- Lookup is combinational on the pre-edge array state: hit = valid[index] && tag_array[index]==tag.
- On hit: hitCount += 1 at the edge; array unchanged.
- On miss: missCount += 1 at the edge; valid[index]=1 and tag_array[index]=tag at the same edge.
  - Allocate-on-miss covers both cold misses and conflict evictions.
- Latency: counter update is visible on the outputs immediately after the edge that sampled the access. Outputs are registered, not combinational.
- Back-to-back accesses to the same block: the first misses and fills at edge k; the second hits at edge k+1. No bypass hazard.
- Back-to-back accesses with the same index and different tag: both miss, and the second evicts the first.
- Exactly one of the two counters increments per non-reset cycle. Invariant: hitCount + missCount = number of non-reset edges since reset (mod 2^32).
- Counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0 with no saturation or flag.
- The address must be a known value on every non-reset edge; the bench holds reset high until it drives a valid address.
- No reads or writes are distinguished; every access is treated as a read-allocate lookup.

Test Plan:
- Reset held 2 cycles, then released with no further edges: hitCount=0, missCount=0.
- Addresses 0x00001000 then 0x00001000, then 0x0000103C (same 64-byte block, different offset): missCount=1, hitCount=2.
- Conflict ping-pong: 0x00000040, 0x00010040 (same index 1, tags 0 and 1), repeated 4 times: missCount=8, hitCount=0.
- Fill 1024 blocks sequentially (0x0 to 0xFFC0, stride 0x40), then repeat the sweep: missCount=1024, hitCount=1024.
- Mid-run reset:
  - Access 0x2000 twice (1 miss, 1 hit), then assert reset 1 cycle.
  - Counters read 0, 0.
  - Access 0x2000 again: missCount=1, hitCount=0 (valid bits cleared).
- Wrap: force hitCount to 0xFFFFFFFF via hierarchical deposit, then perform a hit: hitCount=0, and missCount is unchanged.
